// File: rtl/inst_loader_if.sv
// Host byte-stream link into the instruction loader: valid/ready handshake.
// The host drives data and valid; the loader answers with ready.
interface inst_loader_if;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxReady;

    modport master (output RxData, output RxValid, input RxReady);
    modport slave  (input RxData, input RxValid, output RxReady);
endinterface

// File: rtl/inst_loader.sv
// Boot-time loader: assembles big-endian 16-bit words from a byte stream into instruction RAM
// and holds the CPU in reset until the image is in place. Define CHECKSUM_EN to verify a trailing 16-bit sum.
module inst_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              start,
    inst_loader_if.slave      rx,
    output logic              InstWrite,
    output logic [ADDR_W-1:0] InstWrAddress,
    output logic [15:0]       InstWrData,
    output logic              CpuStart,
    output logic              Loaded,
    output logic              LoadError,
    output logic [ADDR_W:0]   WordCount
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
`ifdef CHECKSUM_EN
        CSUM_HI,
        CSUM_LO,
`endif
        DONE,
        ERROR
    } state_t;

    state_t          state, state_n;
    logic [7:0]      hi_byte;
    logic [ADDR_W:0] n_words;
    logic [15:0]     rx_word;
    logic            xfer;
    logic            last_word;
`ifdef CHECKSUM_EN
    logic [15:0]     csum;
`endif

    assign xfer      = rx.RxValid && rx.RxReady;
    assign rx_word   = {hi_byte, rx.RxData};
    // WordCount still holds the index of the word being completed
    assign last_word = (WordCount + (ADDR_W+1)'(1)) == n_words;

    always_comb begin
        state_n = state;
        if (xfer) begin
            unique case (state)
                LEN_HI:  state_n = LEN_LO;
                LEN_LO: begin
                    if (32'(rx_word) > DEPTH)
                        state_n = ERROR;
                    else if (rx_word == 16'h0000)
`ifdef CHECKSUM_EN
                        state_n = CSUM_HI;
`else
                        state_n = DONE;
`endif
                    else
                        state_n = DATA_HI;
                end
                DATA_HI: state_n = DATA_LO;
                DATA_LO: begin
                    if (!last_word)
                        state_n = DATA_HI;
                    else
`ifdef CHECKSUM_EN
                        state_n = CSUM_HI;
`else
                        state_n = DONE;
`endif
                end
`ifdef CHECKSUM_EN
                CSUM_HI: state_n = CSUM_LO;
                CSUM_LO: state_n = (rx_word == csum) ? DONE : ERROR;
`endif
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            state         <= LEN_HI;
            rx.RxReady    <= 1'b1;
            InstWrite     <= 1'b0;
            InstWrAddress <= '0;
            InstWrData    <= '0;
            CpuStart      <= 1'b1;
            Loaded        <= 1'b0;
            LoadError     <= 1'b0;
            WordCount     <= '0;
            hi_byte       <= '0;
            n_words       <= '0;
`ifdef CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            state      <= state_n;
            rx.RxReady <= (state_n != DONE) && (state_n != ERROR);
            Loaded     <= (state_n == DONE);
            LoadError  <= (state_n == ERROR);
            // Released one edge after DONE so the last write has landed first
            CpuStart   <= (state != DONE);
            InstWrite  <= 1'b0;
            if (xfer) begin
                unique case (state)
                    LEN_LO:  n_words <= (ADDR_W+1)'(rx_word);
                    DATA_LO: begin
                        InstWrite     <= 1'b1;
                        InstWrAddress <= WordCount[ADDR_W-1:0];
                        InstWrData    <= rx_word;
                        WordCount     <= WordCount + (ADDR_W+1)'(1);
`ifdef CHECKSUM_EN
                        csum          <= csum + rx_word;
`endif
                    end
                    default: hi_byte <= rx.RxData;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: images are described at word level, expected writes queued,
// and a monitor pops one entry per InstWrite. Honours CHECKSUM_EN in the same way as the design.
module tb_inst_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              start;
    logic              InstWrite;
    logic [ADDR_W-1:0] InstWrAddress;
    logic [15:0]       InstWrData;
    logic              CpuStart;
    logic              Loaded;
    logic              LoadError;
    logic [ADDR_W:0]   WordCount;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [15:0] img_words[$];

    inst_loader_if rx ();

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK           (CLK),
        .start         (start),
        .rx            (rx),
        .InstWrite     (InstWrite),
        .InstWrAddress (InstWrAddress),
        .InstWrData    (InstWrData),
        .CpuStart      (CpuStart),
        .Loaded        (Loaded),
        .LoadError     (LoadError),
        .WordCount     (WordCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        wr_t e;
        if (InstWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h expected none",
                         InstWrAddress, InstWrData);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(InstWrAddress), 32'(e.addr));
                check("write_data", 32'(InstWrData), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            rx.RxValid = 1'b0;
            @(negedge CLK);
        end
        rx.RxData  = b;
        rx.RxValid = 1'b1;
        t = 0;
        while (rx.RxReady !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (rx.RxReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        rx.RxValid = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("rst_ready",    32'(rx.RxReady),     32'd1);
        check("rst_write",    32'(InstWrite),      32'd0);
        check("rst_addr",     32'(InstWrAddress),  32'd0);
        check("rst_data",     32'(InstWrData),     32'd0);
        check("rst_cpustart", 32'(CpuStart),       32'd1);
        check("rst_loaded",   32'(Loaded),         32'd0);
        check("rst_error",    32'(LoadError),      32'd0);
        check("rst_count",    32'(WordCount),      32'd0);
    endtask

    function automatic bit pick_gap(input int mode, input int idx);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Sends length, img_words and (if enabled) cs; expectations come from the word-level rules.
    task automatic run_image(input int n, input logic [15:0] cs, input int gap_mode);
        bit          exp_err;
        logic [15:0] nl;
        logic [15:0] sum;
        int          exp_wc;
        int          idx;
        nl      = 16'(n);
        sum     = '0;
        exp_err = (n > DEPTH);
        exp_wc  = exp_err ? 0 : n;
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{addr: ADDR_W'(i), data: img_words[i]});
                sum = sum + img_words[i];
            end
        end
`ifdef CHECKSUM_EN
        if (!exp_err && sum != cs) exp_err = 1'b1;
`endif
        idx = 0;
        send_byte(nl[15:8], pick_gap(gap_mode, idx++));
        send_byte(nl[7:0],  pick_gap(gap_mode, idx++));
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                send_byte(img_words[i][15:8], pick_gap(gap_mode, idx++));
                send_byte(img_words[i][7:0],  pick_gap(gap_mode, idx++));
            end
`ifdef CHECKSUM_EN
            send_byte(cs[15:8], pick_gap(gap_mode, idx++));
            send_byte(cs[7:0],  pick_gap(gap_mode, idx++));
`endif
        end
        rx.RxValid = 1'b0;
        check("end_loaded",   32'(Loaded),     32'(!exp_err));
        check("end_error",    32'(LoadError),  32'(exp_err));
        check("end_ready",    32'(rx.RxReady), 32'd0);
        check("end_cpu_held", 32'(CpuStart),   32'd1);
        check("end_count",    32'(WordCount),  32'(exp_wc));
        @(negedge CLK);
        check("cpu_release",  32'(CpuStart),   32'(exp_err));
        check("writes_done",  32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        check("cpu_stays",    32'(CpuStart),   32'(exp_err));
        check("ready_stays",  32'(rx.RxReady), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sum;
        int          n;
        start      = 1'b0;
        rx.RxValid = 1'b0;
        rx.RxData  = '0;
        @(negedge CLK);
        do_reset();

        img_words = '{16'h1234, 16'hABCD, 16'h0001};
        run_image(3, 16'hBE02, 0);
        do_reset();
        run_image(3, 16'hBE02, 1);
        do_reset();

        img_words = {};
        run_image(0, 16'h0000, 0);
        do_reset();
        run_image(DEPTH + 1, 16'h0000, 0);
        do_reset();

        img_words = '{16'h00FF};
        run_image(1, 16'h00FE, 0);
        do_reset();

        // Abort after three bytes; start wins over a byte offered on the same edge
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        rx.RxData  = 8'h55;
        rx.RxValid = 1'b1;
        start      = 1'b1;
        @(negedge CLK);
        start      = 1'b0;
        rx.RxValid = 1'b0;
        check("abort_ready", 32'(rx.RxReady), 32'd1);
        check("abort_count", 32'(WordCount),  32'd0);
        check("abort_write", 32'(InstWrite),  32'd0);
        img_words = '{16'h1111, 16'h2222};
        run_image(2, 16'h3333, 0);
        do_reset();

        for (int it = 0; it < 24; it++) begin
            n = (it % 8 == 5) ? DEPTH : int'($urandom_range(0, 9));
            img_words = {};
            sum = '0;
            for (int i = 0; i < n; i++) begin
                img_words.push_back(16'($urandom));
                sum = sum + img_words[i];
            end
            if ($urandom_range(0, 3) == 0) sum = sum ^ 16'(1 << $urandom_range(0, 15));
            run_image(n, sum, 2);
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader for the single-cycle CPU. It is the write side of the instruction memory that the CPU fetch path reads. It accepts a byte stream from a host link through a valid/ready handshake, assembles 16-bit instructions and writes them sequentially into instruction RAM. While loading, it holds the CPU in reset through the CPU's `start` input, then releases it once the image is complete and, optionally, verified.

## Interface
Parameters:
- ADDR_W, 8, instruction RAM address width; DEPTH = 2^ADDR_W words

Ports:
- CLK  in  1  system clock, rising edge
- start  in  1  synchronous active-high reset
- RxData  in  8  incoming byte
- RxValid  in  1  RxData valid
- RxReady  out  1  loader can accept a byte
- InstWrite  out  1  one-cycle instruction RAM write strobe
- InstWrAddress  out  ADDR_W  write address
- InstWrData  out  16  write data
- CpuStart  out  1  drives the CPU `start` input; 1 = CPU held in reset
- Loaded  out  1  image loaded (and verified when checksum is enabled)
- LoadError  out  1  load aborted
- WordCount  out  ADDR_W+1  words written so far

## Operation
- Byte transfer occurs on a rising CLK edge with RxValid && RxReady. RxData is ignored otherwise.
- Stream format, big-endian: length N (2 bytes), N instruction words (2 bytes each), then a 16-bit checksum (2 bytes) when CHECKSUM_EN is defined.
- FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, DONE, ERROR.
- LEN_HI -> LEN_LO on transfer. LEN_LO -> one of the following on transfer:
  - ERROR if N > DEPTH.
  - DONE if N == 0 and checksum is disabled.
  - CSUM_HI if N == 0 and checksum is enabled.
  - DATA_HI otherwise.
- DATA_HI -> DATA_LO on transfer. DATA_LO -> DATA_HI on transfer while words remain. After word N, DATA_LO -> CSUM_HI when checksum is enabled, otherwise DONE.
- CSUM_HI -> CSUM_LO on transfer. CSUM_LO -> DONE on match, ERROR on mismatch.
- DONE and ERROR are terminal until `start`.
- RxReady = 1 in LEN_*, DATA_*, CSUM_*; 0 in DONE and ERROR.
- Word index k (0-based) is written to InstWrAddress = k with InstWrData = {hi byte, lo byte}. The address never wraps because N <= DEPTH is enforced.
- WordCount increments with each InstWrite, saturates at N, and reaches DEPTH when N == DEPTH.
- The checksum is the 16-bit sum, modulo 2^16, of all N data words. The length word is excluded.

## Timing
- Reset values: RxReady 1, InstWrite 0, InstWrAddress 0, InstWrData 0, CpuStart 1, Loaded 0, LoadError 0, WordCount 0, state LEN_HI.
- All outputs are registered.
- InstWrite is high for exactly one cycle, in the cycle after the DATA_LO byte transfer, with address and data valid in that same cycle.
- Maximum sustained rate is one byte per cycle, so at most one write per two cycles. No write collisions are possible.
- DONE is entered on edge E, the edge after the last required byte.
  - Loaded rises at E.
  - The final InstWrite, if any, is high in the cycle following the last DATA_LO transfer, which is no later than the cycle after E.
  - CpuStart falls at E+1, so memory is complete before the CPU leaves reset.
- In ERROR: LoadError = 1, CpuStart stays 1, Loaded stays 0.
- `start` asserted mid-load:
  - The next edge returns all state and outputs to reset values.
  - Any pending InstWrite is dropped.
  - Words already written to RAM are not erased.
- `start` has priority over a simultaneous byte transfer; that byte is discarded.

## Configuration
- CHECKSUM_EN defined: the CSUM_HI and CSUM_LO states exist, a running 16-bit accumulator is maintained, and a mismatch leads to ERROR with the CPU kept in reset.
- CHECKSUM_EN undefined: no checksum states or accumulator. DONE follows the last data word (or the length word when N == 0). LoadError is asserted only for N > DEPTH.

## Test plan
- Load N=3 with words 0x1234, 0xABCD, 0x0001 back-to-back, plus checksum 0xBE02 when enabled -> writes at addresses 0/1/2 with matching data, Loaded=1, CpuStart falls one cycle after DONE, RxReady=0.
- Same image with RxValid toggled every other cycle -> identical writes. No byte is lost or duplicated.
- N=0 (bytes 0x00 0x00, plus checksum 0x0000 if enabled) -> no InstWrite, Loaded=1, CpuStart=0.
- N=DEPTH+1 -> ERROR after the second byte, LoadError=1, CpuStart=1, no InstWrite.
- CHECKSUM_EN: N=1, word 0x00FF, checksum 0x00FE -> one write, then LoadError=1, Loaded=0, CpuStart=1.
- `start` pulsed after 3 bytes of a load, then a full N=2 image sent -> first partial word never written, fresh load writes addresses 0/1, WordCount=2.
